// File: rtl/axil_arb_pkg.sv
// Shared types for the two-master AXI4-Lite arbiter.
// Optional feature macro: AXIL_ARB_ROUND_ROBIN_EN (resolved in axil_arb_pick).
package axil_arb_pkg;

    localparam int NUM_M = 2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

endpackage

// File: rtl/axil_arb_pick.sv
// Combinational 2-way picker used by each arbitration path.
// AXIL_ARB_ROUND_ROBIN_EN defined: a tie goes to the master other than `last`.
// Undefined: master 0 always wins a tie and `last` is ignored.
module axil_arb_pick
    import axil_arb_pkg::*;
(
    input  logic [NUM_M-1:0] req,
    input  logic             last,
    output logic             gnt_idx,
    output logic             gnt_any
);

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    // Round-robin: alternate on a tie, otherwise take the lone requester
    always_comb begin
        gnt_any = |req;
        gnt_idx = 1'b0;
        if (req[0] && req[1]) gnt_idx = ~last;
        else                  gnt_idx = req[1];
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Fixed priority: master 0 first
    always_comb begin
        gnt_any = |req;
        gnt_idx = ~req[0] & req[1];
    end
`endif

endmodule

// File: rtl/axil_arbiter_2m.sv
// Two-master AXI4-Lite arbiter onto one slave port. Read and write paths are
// arbitrated independently, one outstanding transaction each; the grant is
// held from address issue until the B / R handshake.
// Optional feature macro: AXIL_ARB_ROUND_ROBIN_EN (round-robin tie-break).
module axil_arbiter_2m
    import axil_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    // master 0
    input  logic                m0_AWvalid,
    input  logic [ADDR_W-1:0]   m0_AWdata,
    input  logic [2:0]          m0_AWprot,
    output logic                m0_AWready,
    input  logic                m0_Wvalid,
    input  logic [DATA_W-1:0]   m0_Wdata,
    input  logic [DATA_W/8-1:0] m0_Wstrb,
    output logic                m0_Wready,
    output logic                m0_Bvalid,
    input  logic                m0_Bready,
    input  logic                m0_ARvalid,
    input  logic [ADDR_W-1:0]   m0_ARdata,
    input  logic [2:0]          m0_ARprot,
    output logic                m0_ARready,
    output logic                m0_Rvalid,
    output logic [DATA_W-1:0]   m0_Rdata,
    input  logic                m0_Rready,
    // master 1
    input  logic                m1_AWvalid,
    input  logic [ADDR_W-1:0]   m1_AWdata,
    input  logic [2:0]          m1_AWprot,
    output logic                m1_AWready,
    input  logic                m1_Wvalid,
    input  logic [DATA_W-1:0]   m1_Wdata,
    input  logic [DATA_W/8-1:0] m1_Wstrb,
    output logic                m1_Wready,
    output logic                m1_Bvalid,
    input  logic                m1_Bready,
    input  logic                m1_ARvalid,
    input  logic [ADDR_W-1:0]   m1_ARdata,
    input  logic [2:0]          m1_ARprot,
    output logic                m1_ARready,
    output logic                m1_Rvalid,
    output logic [DATA_W-1:0]   m1_Rdata,
    input  logic                m1_Rready,
    // slave
    output logic                s_AWvalid,
    output logic [ADDR_W-1:0]   s_AWdata,
    output logic [2:0]          s_AWprot,
    input  logic                s_AWready,
    output logic                s_Wvalid,
    output logic [DATA_W-1:0]   s_Wdata,
    output logic [DATA_W/8-1:0] s_Wstrb,
    input  logic                s_Wready,
    input  logic                s_Bvalid,
    output logic                s_Bready,
    output logic                s_ARvalid,
    output logic [ADDR_W-1:0]   s_ARdata,
    output logic [2:0]          s_ARprot,
    input  logic                s_ARready,
    input  logic                s_Rvalid,
    input  logic [DATA_W-1:0]   s_Rdata,
    output logic                s_Rready
);

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic     wg_q, wg_d, rg_q, rg_d;
    logic     aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic     w_last, r_last;
    logic     w_pick_idx, w_pick_any, r_pick_idx, r_pick_any;

    axil_arb_pick u_w_pick (
        .req     ({m1_AWvalid, m0_AWvalid}),
        .last    (w_last),
        .gnt_idx (w_pick_idx),
        .gnt_any (w_pick_any)
    );

    axil_arb_pick u_r_pick (
        .req     ({m1_ARvalid, m0_ARvalid}),
        .last    (r_last),
        .gnt_idx (r_pick_idx),
        .gnt_any (r_pick_any)
    );

    // Granted master's request-side signals
    logic                sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic [ADDR_W-1:0]   sel_awdata, sel_ardata;
    logic [2:0]          sel_awprot, sel_arprot;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_wstrb;

    assign sel_awvalid = wg_q ? m1_AWvalid : m0_AWvalid;
    assign sel_awdata  = wg_q ? m1_AWdata  : m0_AWdata;
    assign sel_awprot  = wg_q ? m1_AWprot  : m0_AWprot;
    assign sel_wvalid  = wg_q ? m1_Wvalid  : m0_Wvalid;
    assign sel_wdata   = wg_q ? m1_Wdata   : m0_Wdata;
    assign sel_wstrb   = wg_q ? m1_Wstrb   : m0_Wstrb;
    assign sel_bready  = wg_q ? m1_Bready  : m0_Bready;
    assign sel_arvalid = rg_q ? m1_ARvalid : m0_ARvalid;
    assign sel_ardata  = rg_q ? m1_ARdata  : m0_ARdata;
    assign sel_arprot  = rg_q ? m1_ARprot  : m0_ARprot;
    assign sel_rready  = rg_q ? m1_Rready  : m0_Rready;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    logic w_last_q, w_last_d, r_last_q, r_last_d;
    assign w_last = w_last_q;
    assign r_last = r_last_q;

    // Round-robin pointers; reset to 1 so master 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            w_last_q <= 1'b1;
            r_last_q <= 1'b1;
        end else begin
            w_last_q <= w_last_d;
            r_last_q <= r_last_d;
        end
    end
`else
    assign w_last = 1'b1;
    assign r_last = 1'b1;
`endif

    // State, grant and sticky handshake flags
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wg_q      <= 1'b0;
            rg_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wg_q      <= wg_d;
            rg_q      <= rg_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Write path: next state and AW/W/B routing
    always_comb begin
        w_state_d  = w_state_q;
        wg_d       = wg_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        w_last_d   = w_last_q;
`endif
        s_AWvalid  = 1'b0;
        s_AWdata   = '0;
        s_AWprot   = '0;
        s_Wvalid   = 1'b0;
        s_Wdata    = '0;
        s_Wstrb    = '0;
        s_Bready   = 1'b0;
        m0_AWready = 1'b0;
        m1_AWready = 1'b0;
        m0_Wready  = 1'b0;
        m1_Wready  = 1'b0;
        m0_Bvalid  = 1'b0;
        m1_Bvalid  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (w_pick_any) begin
                    wg_d      = w_pick_idx;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                s_AWvalid  = sel_awvalid & ~aw_done_q;
                s_AWdata   = sel_awdata;
                s_AWprot   = sel_awprot;
                s_Wvalid   = sel_wvalid & ~w_done_q;
                s_Wdata    = sel_wdata;
                s_Wstrb    = sel_wstrb;
                m0_AWready = ~wg_q & ~aw_done_q & s_AWready;
                m1_AWready =  wg_q & ~aw_done_q & s_AWready;
                m0_Wready  = ~wg_q & ~w_done_q & s_Wready;
                m1_Wready  =  wg_q & ~w_done_q & s_Wready;
                aw_done_d  = aw_done_q | (s_AWvalid & s_AWready);
                w_done_d   = w_done_q  | (s_Wvalid & s_Wready);
                if (aw_done_d && w_done_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_Bready  = sel_bready;
                m0_Bvalid = ~wg_q & s_Bvalid;
                m1_Bvalid =  wg_q & s_Bvalid;
                if (s_Bvalid && sel_bready) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_IDLE;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
                    w_last_d  = wg_q;
`endif
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path: next state and AR/R routing
    always_comb begin
        r_state_d  = r_state_q;
        rg_d       = rg_q;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        r_last_d   = r_last_q;
`endif
        s_ARvalid  = 1'b0;
        s_ARdata   = '0;
        s_ARprot   = '0;
        s_Rready   = 1'b0;
        m0_ARready = 1'b0;
        m1_ARready = 1'b0;
        m0_Rvalid  = 1'b0;
        m1_Rvalid  = 1'b0;
        m0_Rdata   = '0;
        m1_Rdata   = '0;
        unique case (r_state_q)
            R_IDLE: begin
                if (r_pick_any) begin
                    rg_d      = r_pick_idx;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                s_ARvalid  = sel_arvalid;
                s_ARdata   = sel_ardata;
                s_ARprot   = sel_arprot;
                m0_ARready = ~rg_q & s_ARready;
                m1_ARready =  rg_q & s_ARready;
                if (sel_arvalid && s_ARready) r_state_d = R_DATA;
            end
            R_DATA: begin
                s_Rready  = sel_rready;
                m0_Rvalid = ~rg_q & s_Rvalid;
                m1_Rvalid =  rg_q & s_Rvalid;
                if (rg_q) m1_Rdata = s_Rdata;
                else      m0_Rdata = s_Rdata;
                if (s_Rvalid && sel_rready) begin
                    r_state_d = R_IDLE;
`ifdef AXIL_ARB_ROUND_ROBIN_EN
                    r_last_d  = rg_q;
`endif
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_arbiter_2m.sv
// Directed self-checking bench for axil_arbiter_2m. Expected grant order
// follows AXIL_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_axil_arbiter_2m;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_AWvalid, m0_Wvalid, m0_Bready, m0_ARvalid, m0_Rready;
    logic [31:0] m0_AWdata, m0_Wdata, m0_ARdata;
    logic [2:0]  m0_AWprot, m0_ARprot;
    logic [3:0]  m0_Wstrb;
    logic        m0_AWready, m0_Wready, m0_Bvalid, m0_ARready, m0_Rvalid;
    logic [31:0] m0_Rdata;
    logic        m1_AWvalid, m1_Wvalid, m1_Bready, m1_ARvalid, m1_Rready;
    logic [31:0] m1_AWdata, m1_Wdata, m1_ARdata;
    logic [2:0]  m1_AWprot, m1_ARprot;
    logic [3:0]  m1_Wstrb;
    logic        m1_AWready, m1_Wready, m1_Bvalid, m1_ARready, m1_Rvalid;
    logic [31:0] m1_Rdata;
    logic        s_AWvalid, s_Wvalid, s_Bready, s_ARvalid, s_Rready;
    logic [31:0] s_AWdata, s_Wdata, s_ARdata;
    logic [2:0]  s_AWprot, s_ARprot;
    logic [3:0]  s_Wstrb;
    logic        s_AWready, s_Wready, s_Bvalid, s_ARready, s_Rvalid;
    logic [31:0] s_Rdata;

    int checks = 0;
    int failures = 0;
    int wbeats = 0;

    always #5 clock = ~clock;

    axil_arbiter_2m dut (
        .clock(clock), .reset(reset),
        .m0_AWvalid(m0_AWvalid), .m0_AWdata(m0_AWdata), .m0_AWprot(m0_AWprot), .m0_AWready(m0_AWready),
        .m0_Wvalid(m0_Wvalid), .m0_Wdata(m0_Wdata), .m0_Wstrb(m0_Wstrb), .m0_Wready(m0_Wready),
        .m0_Bvalid(m0_Bvalid), .m0_Bready(m0_Bready),
        .m0_ARvalid(m0_ARvalid), .m0_ARdata(m0_ARdata), .m0_ARprot(m0_ARprot), .m0_ARready(m0_ARready),
        .m0_Rvalid(m0_Rvalid), .m0_Rdata(m0_Rdata), .m0_Rready(m0_Rready),
        .m1_AWvalid(m1_AWvalid), .m1_AWdata(m1_AWdata), .m1_AWprot(m1_AWprot), .m1_AWready(m1_AWready),
        .m1_Wvalid(m1_Wvalid), .m1_Wdata(m1_Wdata), .m1_Wstrb(m1_Wstrb), .m1_Wready(m1_Wready),
        .m1_Bvalid(m1_Bvalid), .m1_Bready(m1_Bready),
        .m1_ARvalid(m1_ARvalid), .m1_ARdata(m1_ARdata), .m1_ARprot(m1_ARprot), .m1_ARready(m1_ARready),
        .m1_Rvalid(m1_Rvalid), .m1_Rdata(m1_Rdata), .m1_Rready(m1_Rready),
        .s_AWvalid(s_AWvalid), .s_AWdata(s_AWdata), .s_AWprot(s_AWprot), .s_AWready(s_AWready),
        .s_Wvalid(s_Wvalid), .s_Wdata(s_Wdata), .s_Wstrb(s_Wstrb), .s_Wready(s_Wready),
        .s_Bvalid(s_Bvalid), .s_Bready(s_Bready),
        .s_ARvalid(s_ARvalid), .s_ARdata(s_ARdata), .s_ARprot(s_ARprot), .s_ARready(s_ARready),
        .s_Rvalid(s_Rvalid), .s_Rdata(s_Rdata), .s_Rready(s_Rready)
    );

    logic m0_any, m1_any, s_any;
    assign m0_any = |{m0_AWready, m0_Wready, m0_Bvalid, m0_ARready, m0_Rvalid, m0_Rdata};
    assign m1_any = |{m1_AWready, m1_Wready, m1_Bvalid, m1_ARready, m1_Rvalid, m1_Rdata};
    assign s_any  = |{s_AWvalid, s_AWdata, s_AWprot, s_Wvalid, s_Wdata, s_Wstrb, s_Bready,
                      s_ARvalid, s_ARdata, s_ARprot, s_Rready};

    // W beats actually accepted by the slave
    always @(posedge clock) if (s_Wvalid && s_Wready) wbeats <= wbeats + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic exp_g[4];
    int   wb0;

    initial begin
        reset = 1'b1;
        {m0_AWvalid, m0_Wvalid, m0_Bready, m0_ARvalid, m0_Rready} = '0;
        {m1_AWvalid, m1_Wvalid, m1_Bready, m1_ARvalid, m1_Rready} = '0;
        {m0_AWdata, m0_Wdata, m0_ARdata, m0_AWprot, m0_ARprot, m0_Wstrb} = '0;
        {m1_AWdata, m1_Wdata, m1_ARdata, m1_AWprot, m1_ARprot, m1_Wstrb} = '0;
        {s_AWready, s_Wready, s_Bvalid, s_ARready, s_Rvalid} = '0;
        s_Rdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_m0", {63'd0, m0_any}, 64'd0);
        chk("reset_m1", {63'd0, m1_any}, 64'd0);
        chk("reset_s",  {63'd0, s_any},  64'd0);

        // ---- single write by m0, slave ready immediately
        m0_AWvalid = 1; m0_AWdata = 32'h0000_0010; m0_AWprot = 3'b010;
        m0_Wvalid = 1; m0_Wdata = 32'hDEAD_BEEF; m0_Wstrb = 4'hF; m0_Bready = 1;
        s_AWready = 1; s_Wready = 1;
        #1;
        chk("wr_arb_latency", {63'd0, s_AWvalid}, 64'd0);
        tick();
        chk("wr_s_awvalid", {63'd0, s_AWvalid}, 64'd1);
        chk("wr_s_awdata", {32'd0, s_AWdata}, 64'h10);
        chk("wr_s_awprot", {61'd0, s_AWprot}, 64'd2);
        chk("wr_s_wvalid", {63'd0, s_Wvalid}, 64'd1);
        chk("wr_s_wdata", {32'd0, s_Wdata}, 64'hDEAD_BEEF);
        chk("wr_s_wstrb", {60'd0, s_Wstrb}, 64'hF);
        chk("wr_m0_rdy", {62'd0, m0_AWready, m0_Wready}, 64'd3);
        chk("wr_m1_quiet_a", {63'd0, m1_any}, 64'd0);
        tick();
        m0_AWvalid = 0; m0_Wvalid = 0; s_Bvalid = 1;
        #1;
        chk("wr_resp_awvalid", {63'd0, s_AWvalid}, 64'd0);
        chk("wr_m0_bvalid", {63'd0, m0_Bvalid}, 64'd1);
        chk("wr_s_bready", {63'd0, s_Bready}, 64'd1);
        chk("wr_m1_quiet_b", {63'd0, m1_any}, 64'd0);
        tick();
        s_Bvalid = 0;
        #1;
        chk("wr_done_bvalid", {63'd0, m0_Bvalid}, 64'd0);

        // ---- simultaneous reads from both masters, four grants
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
        m0_ARvalid = 1; m0_ARdata = 32'h100; m0_Rready = 1;
        m1_ARvalid = 1; m1_ARdata = 32'h200; m1_Rready = 1;
        s_ARready = 1; s_Rvalid = 1; s_Rdata = 32'hCAFE_0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rd%0d_araddr", k), {32'd0, s_ARdata}, exp_g[k] ? 64'h200 : 64'h100);
            chk($sformatf("rd%0d_arready", k), {62'd0, m1_ARready, m0_ARready}, exp_g[k] ? 64'd2 : 64'd1);
            tick();
            chk($sformatf("rd%0d_rvalid", k), {62'd0, m1_Rvalid, m0_Rvalid}, exp_g[k] ? 64'd2 : 64'd1);
            tick();
        end
        m0_ARvalid = 0; m1_ARvalid = 0; s_Rvalid = 0; s_ARready = 0;
        tick();

        // ---- W handshake before AW
        wb0 = wbeats;
        m0_AWvalid = 1; m0_AWdata = 32'h20; m0_AWprot = 3'b000;
        m0_Wvalid = 1; m0_Wdata = 32'h55; s_AWready = 0; s_Wready = 1;
        tick();
        chk("wfirst_c1_wvalid", {63'd0, s_Wvalid}, 64'd1);
        tick();
        chk("wfirst_c2_wvalid", {63'd0, s_Wvalid}, 64'd0);
        chk("wfirst_c2_wready", {63'd0, m0_Wready}, 64'd0);
        chk("wfirst_c2_awvalid", {63'd0, s_AWvalid}, 64'd1);
        tick();
        s_AWready = 1;
        #1;
        chk("wfirst_c3_awrdy", {63'd0, m0_AWready}, 64'd1);
        chk("wfirst_c3_nob", {63'd0, s_Bready}, 64'd0);
        tick();
        m0_AWvalid = 0; m0_Wvalid = 0; s_Bvalid = 1;
        #1;
        chk("wfirst_resp_b", {63'd0, m0_Bvalid}, 64'd1);
        tick();
        s_Bvalid = 0;
        chk("wfirst_one_beat", 64'(wbeats - wb0), 64'd1);

        // ---- concurrent: m0 writes 0x40, m1 reads 0x80
        m0_AWvalid = 1; m0_AWdata = 32'h40; m0_Wvalid = 1; m0_Wdata = 32'hA5;
        m1_ARvalid = 1; m1_ARdata = 32'h80;
        s_AWready = 1; s_Wready = 1; s_ARready = 1;
        tick();
        chk("conc_aw", {31'd0, s_AWvalid, s_AWdata}, 64'h1_0000_0040);
        chk("conc_ar", {31'd0, s_ARvalid, s_ARdata}, 64'h1_0000_0080);
        tick();
        m0_AWvalid = 0; m0_Wvalid = 0; m1_ARvalid = 0;
        s_Rvalid = 1; s_Rdata = 32'h1234_5678; s_Bvalid = 1;
        #1;
        chk("conc_m1_rdata", {32'd0, m1_Rdata}, 64'h1234_5678);
        chk("conc_m0_rdata", {32'd0, m0_Rdata}, 64'd0);
        chk("conc_rvalid", {62'd0, m1_Rvalid, m0_Rvalid}, 64'd2);
        chk("conc_bvalid", {62'd0, m1_Bvalid, m0_Bvalid}, 64'd1);
        tick();
        s_Rvalid = 0; s_Bvalid = 0;

        // ---- reset during R_DATA
        m1_ARvalid = 1; m1_ARdata = 32'h300; m1_Rready = 0;
        tick();
        tick();
        m1_ARvalid = 0; s_Rvalid = 1; s_Rdata = 32'h77;
        #1;
        chk("rst_pre_rvalid", {63'd0, m1_Rvalid}, 64'd1);
        reset = 1;
        tick();
        reset = 0; s_Rvalid = 0;
        #1;
        chk("rst_m0_zero", {63'd0, m0_any}, 64'd0);
        chk("rst_m1_zero", {63'd0, m1_any}, 64'd0);
        chk("rst_s_zero", {63'd0, s_any}, 64'd0);
        m1_ARvalid = 1; m1_Rready = 1;
        tick();
        chk("rst_fresh_ar", {31'd0, s_ARvalid, s_ARdata}, 64'h1_0000_0300);
        chk("rst_fresh_rdy", {62'd0, m1_ARready, m0_ARready}, 64'd2);
        tick();
        m1_ARvalid = 0; s_Rvalid = 1;
        tick();
        s_Rvalid = 0;

        // ---- back-pressure on m1 R while m0 waits for a read
        m1_ARvalid = 1; m1_ARdata = 32'h500; m1_Rready = 0;
        tick();
        chk("bp_ar_m1", {31'd0, s_ARvalid, s_ARdata}, 64'h1_0000_0500);
        tick();
        m1_ARvalid = 0; m0_ARvalid = 1; m0_ARdata = 32'h600; s_Rvalid = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp%0d_rvalid", k), {63'd0, m1_Rvalid}, 64'd1);
            chk($sformatf("bp%0d_noar", k), {62'd0, s_ARvalid, m0_ARready}, 64'd0);
            tick();
        end
        m1_Rready = 1;
        #1;
        chk("bp_s_rready", {63'd0, s_Rready}, 64'd1);
        tick();
        s_Rvalid = 0;
        #1;
        chk("bp_idle_noar", {63'd0, s_ARvalid}, 64'd0);
        tick();
        chk("bp_next_m0", {31'd0, s_ARvalid, s_ARdata}, 64'h1_0000_0600);
        tick();
        m0_ARvalid = 0; s_Rvalid = 1;
        tick();
        s_Rvalid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
